four_bit_comparator: RTL and testbench

//  - Registered magnitude comparator: compares operands A and B, reports the result
//    as a 2-bit encoded flag plus one-hot less/equal/greater outputs.
//  - Default width 4; unsigned by default, optional two's-complement mode.
//  - Leaf datapath block; results feed control/branch logic in the comparator library.

---
 rtl/comparator_pkg.sv | 16 +
 rtl/cmp_slice4.sv | 27 ++
 rtl/four_bit_comparator.sv | 84 ++++++++
 tb/tb_four_bit_comparator.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/comparator_pkg.sv
// rtl/comparator_pkg.sv - shared result encoding and slicing constants for the comparator library
package comparator_pkg;

  typedef logic [1:0] cmp_flag_t;

  localparam cmp_flag_t FLAG_EQ = 2'b00;
  localparam cmp_flag_t FLAG_LT = 2'b01;
  localparam cmp_flag_t FLAG_GT = 2'b10;

  localparam int SLICE_W = 4;

  function automatic int num_slices(input int width);
    return (width + SLICE_W - 1) / SLICE_W;
  endfunction

endpackage

// File: rtl/cmp_slice4.sv
// rtl/cmp_slice4.sv - one 4-bit magnitude slice of the MSB-first compare cascade
module cmp_slice4
  import comparator_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               lt_in,
  input  logic               eq_in,
  input  logic               gt_in,
  output logic               lt,
  output logic               eq,
  output logic               gt
);

  // A higher slice that already differs decides the result; only a tie lets this slice look.
  always_comb begin
    lt = lt_in;
    eq = eq_in;
    gt = gt_in;
    if (eq_in) begin
      lt = (a < b);
      eq = (a == b);
      gt = (a > b);
    end
  end

endmodule

// File: rtl/four_bit_comparator.sv
// rtl/four_bit_comparator.sv - registered unsigned/signed magnitude comparator built from 4-bit slices
module four_bit_comparator
  import comparator_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output cmp_flag_t        flag,
  output logic             less,
  output logic             equal,
  output logic             greater,
  output logic             out_valid
);

  localparam int NSLICE = num_slices(WIDTH);
  localparam int PW     = NSLICE * SLICE_W;
  localparam int MSB    = WIDTH - 1;

  logic [PW-1:0] a_pad;
  logic [PW-1:0] b_pad;
  logic [NSLICE:0] lt_c;
  logic [NSLICE:0] eq_c;
  logic [NSLICE:0] gt_c;
  logic lt_nxt;
  logic eq_nxt;
  logic gt_nxt;

  assign a_pad = PW'(A);
  assign b_pad = PW'(B);

  assign lt_c[NSLICE] = 1'b0;
  assign eq_c[NSLICE] = 1'b1;
  assign gt_c[NSLICE] = 1'b0;

  // Index NSLICE is the cascade seed; slice s feeds its verdict down to index s.
  for (genvar s = 0; s < NSLICE; s++) begin : g_slice
    cmp_slice4 u_slice (
      .a     (a_pad[s*SLICE_W +: SLICE_W]),
      .b     (b_pad[s*SLICE_W +: SLICE_W]),
      .lt_in (lt_c[s+1]),
      .eq_in (eq_c[s+1]),
      .gt_in (gt_c[s+1]),
      .lt    (lt_c[s]),
      .eq    (eq_c[s]),
      .gt    (gt_c[s])
    );
  end

  // Differing sign bits settle a two's-complement compare; equal ones leave the unsigned order intact.
  always_comb begin
    lt_nxt = lt_c[0];
    eq_nxt = eq_c[0];
    gt_nxt = gt_c[0];
    if (SIGNED && (A[MSB] != B[MSB])) begin
      lt_nxt = A[MSB];
      eq_nxt = 1'b0;
      gt_nxt = B[MSB];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag      <= FLAG_EQ;
      less      <= 1'b0;
      equal     <= 1'b0;
      greater   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        flag    <= {gt_nxt, lt_nxt};
        less    <= lt_nxt;
        equal   <= eq_nxt;
        greater <= gt_nxt;
      end
    end
  end

endmodule

// File: tb/tb_four_bit_comparator.sv
// tb/tb_four_bit_comparator.sv - scoreboard bench for unsigned, signed and multi-slice comparators
module tb_four_bit_comparator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic [6:0] a7;
  logic [6:0] b7;

  logic [1:0] u_flag, s_flag, w_flag;
  logic       u_less, u_equal, u_greater, u_out_valid;
  logic       s_less, s_equal, s_greater, s_out_valid;
  logic       w_less, w_equal, w_greater, w_out_valid;

  always #5 clk = ~clk;

  four_bit_comparator #(.WIDTH(4), .SIGNED(1'b0)) dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(a), .B(b),
    .flag(u_flag), .less(u_less), .equal(u_equal), .greater(u_greater), .out_valid(u_out_valid)
  );

  four_bit_comparator #(.WIDTH(4), .SIGNED(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(a), .B(b),
    .flag(s_flag), .less(s_less), .equal(s_equal), .greater(s_greater), .out_valid(s_out_valid)
  );

  four_bit_comparator #(.WIDTH(7), .SIGNED(1'b1)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(a7), .B(b7),
    .flag(w_flag), .less(w_less), .equal(w_equal), .greater(w_greater), .out_valid(w_out_valid)
  );

  typedef struct packed {
    logic [1:0] fu;
    logic [1:0] fs;
    logic [1:0] fw;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  bit   have;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] model(input int av, input int bv, input int w, input bit sgn);
    int x;
    int y;
    x = av;
    y = bv;
    if (sgn) begin
      if (x >= (1 << (w - 1))) x -= (1 << w);
      if (y >= (1 << (w - 1))) y -= (1 << w);
    end
    if (x < y) return 2'b01;
    if (x > y) return 2'b10;
    return 2'b00;
  endfunction

  task automatic check_out(input string tag, input logic [1:0] f, input logic l, input logic e,
                           input logic g, input logic [1:0] ef, input bit hv);
    check({tag, ".flag"},    f, ef);
    check({tag, ".less"},    l, hv && (ef == 2'b01));
    check({tag, ".equal"},   e, hv && (ef == 2'b00));
    check({tag, ".greater"}, g, hv && (ef == 2'b10));
    if (hv) check({tag, ".onehot"}, l + e + g, 1);
  endtask

  task automatic check_all();
    check_out("u", u_flag, u_less, u_equal, u_greater, last.fu, have);
    check_out("s", s_flag, s_less, s_equal, s_greater, last.fs, have);
    check_out("w", w_flag, w_less, w_equal, w_greater, last.fw, have);
  endtask

  task automatic cycle(input bit v, input logic [3:0] av, input logic [3:0] bv,
                       input logic [6:0] a7v, input logic [6:0] b7v);
    in_valid = v;
    a  = av;
    b  = bv;
    a7 = a7v;
    b7 = b7v;
    if (v) sb.push_back('{model(av, bv, 4, 0), model(av, bv, 4, 1), model(a7v, b7v, 7, 1)});
    @(posedge clk);
    #1;
    check("u.out_valid", u_out_valid, v);
    check("s.out_valid", s_out_valid, v);
    check("w.out_valid", w_out_valid, v);
    if (v) begin
      if (sb.size() == 0) check("sb_underflow", 1, 0);
      else begin
        last = sb.pop_front();
        have = 1'b1;
      end
    end
    check_all();
  endtask

  initial begin
    logic [7:0] p;
    logic [6:0] ra;
    logic [6:0] rb;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a  = '0;
    b  = '0;
    a7 = '0;
    b7 = '0;
    have = 1'b0;
    last = '0;

    #12;
    check("rst.out_valid", u_out_valid | s_out_valid | w_out_valid, 0);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    cycle(1'b1, 4'b1010, 4'b1100, 7'h7F, 7'h00);
    check("spec.lt", {u_flag, u_less}, {2'b01, 1'b1});
    cycle(1'b1, 4'b1111, 4'b1011, 7'h05, 7'h04);
    check("spec.gt", {u_flag, u_greater}, {2'b10, 1'b1});
    cycle(1'b1, 4'b1010, 4'b1010, 7'h40, 7'h3F);
    check("spec.eq", {u_flag, u_equal}, {2'b00, 1'b1});
    cycle(1'b1, 4'b1111, 4'b0001, 7'h12, 7'h52);
    check("spec.signed", {s_flag, u_flag}, {2'b01, 2'b10});
    cycle(1'b1, 4'b0000, 4'b0000, 7'h00, 7'h00);
    cycle(1'b1, 4'b1111, 4'b0000, 7'h3F, 7'h40);
    cycle(1'b0, 4'b0000, 4'b1111, 7'h00, 7'h7F);
    cycle(1'b1, 4'b0111, 4'b1000, 7'h10, 7'h11);

    #2;
    rst_n = 1'b0;
    #1;
    have = 1'b0;
    last = '0;
    sb.delete();
    check("async_rst.out_valid", u_out_valid | s_out_valid | w_out_valid, 0);
    check_all();
    @(posedge clk);
    #1;
    check("held_rst.out_valid", u_out_valid | s_out_valid | w_out_valid, 0);
    check_all();
    in_valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 4'b0011, 4'b0001, 7'h01, 7'h02);
    cycle(1'b0, 4'b0011, 4'b0001, 7'h01, 7'h02);
    cycle(1'b1, 4'b0011, 4'b0001, 7'h01, 7'h02);

    for (int i = 0; i < 256; i++) begin
      p  = i[7:0];
      ra = 7'($urandom);
      rb = (i % 16 == 0) ? ra : 7'($urandom);
      cycle(1'b1, p[7:4], p[3:0], ra, rb);
    end
    cycle(1'b0, 4'b0000, 4'b0000, 7'h00, 7'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
